// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
// Holds the opcode numbers for both opcode pages, the two-state control FSM
// encoding and a sign-extension helper used for the immediate field.
package alu_pkg;

    // Page 0: base ISA opcodes
    localparam int OP_MOVE = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_NOT  = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_SLT  = 5;
    localparam int OP_SLL  = 6;
    localparam int OP_SRL  = 7;
    localparam int OP_J    = 8;
    localparam int OP_JAL  = 9;
    localparam int OP_LW   = 10;
    localparam int OP_SW   = 11;
    localparam int OP_BEQ  = 12;
    localparam int OP_BNE  = 13;
    localparam int OP_ADDI = 14;
    localparam int OP_LI   = 15;

    // Page 1: extension opcodes (bit 4 set)
    localparam int OP_SUB  = 16;
    localparam int OP_MUL  = 17;
    localparam int OP_SRA  = 18;
    localparam int OP_XOR  = 19;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Sign-extend the low 'w' bits of 'val' to 32 bits (1 <= w <= 32).
    // Shifting the field up to bit 31 and arithmetic-shifting it back down
    // replicates its top bit without a variable bit-select.
    function automatic logic [31:0] sext(input logic [31:0] val, input int w);
        logic signed [31:0] t;
        t = $signed(val << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        capture a and b and begin a WIDTH-iteration multiply
//   a, b         multiplicand and multiplier (sampled only on start)
//   busy         a multiply is in progress (including the done cycle)
//   done         product is final; held for one cycle, then busy drops
//   product      full 2*WIDTH-bit unsigned product
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic [WIDTH:0]     w_sum;

    // The product register starts as {0, multiplier}. Each iteration adds the
    // multiplicand into the upper half when the current multiplier LSB is set,
    // then shifts the whole register (with the add carry) right by one.
    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

    assign done    = r_busy && (r_count == CNT_W'(WIDTH));
    assign busy    = r_busy;
    assign product = r_prod;

    // Multiply datapath and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_mcand <= a;
            r_prod  <= {{WIDTH{1'b0}}, b};
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: parametrised ALU with a registered result stage and valid/ready
// handshakes on both sides. Single-cycle ops have latency 1; MUL runs on the
// iterative multiplier and back-pressures the requester while busy.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   in_valid, in_ready     request handshake
//   op, imm, in0, in1, pc  request fields, sampled on accept
//   out_valid, out_ready   result handshake
//   out                    result
//   take_branch            jump or branch taken
//   overflow               signed overflow (ADD/SUB/ADDI) or MUL high half nonzero
//   zero                   out == 0
//   illegal                op undefined
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             take_branch,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [31:0]            w_opCode;
    logic                   w_isMul;
    logic                   w_accept;
    logic                   w_mulStart;
    logic                   w_mulBusy;
    logic                   w_mulDone;
    logic [2*WIDTH-1:0]     w_mulProduct;

    logic [WIDTH-1:0]       w_sextImm;
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_negIn1;
    logic [WIDTH-1:0]       w_addi;
    logic signed [WIDTH-1:0] w_sra;

    logic [WIDTH-1:0]       w_result;
    logic                   w_takeBranch;
    logic                   w_overflow;
    logic                   w_illegal;

    logic [WIDTH-1:0]       r_out;
    logic                   r_outValid;
    logic                   r_takeBranch;
    logic                   r_overflow;
    logic                   r_zero;
    logic                   r_illegal;

    assign w_opCode  = 32'(op);
    assign w_isMul   = (w_opCode == OP_MUL);

    // A new request is taken only when idle and the result slot is free or
    // being drained this same cycle, which gives back-to-back throughput.
    assign in_ready   = (r_state == IDLE) && !w_mulBusy && (!r_outValid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mulStart = w_accept && w_isMul;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mulStart),
        .a       (in0),
        .b       (in1),
        .busy    (w_mulBusy),
        .done    (w_mulDone),
        .product (w_mulProduct)
    );

    assign w_sextImm = WIDTH'(sext(32'(imm), IMM_W));
    assign w_sum     = in0 + in1;
    assign w_diff    = in0 - in1;
    assign w_negIn1  = '0 - in1;
    assign w_addi    = in1 + w_sextImm;
    assign w_sra     = $signed(in1) >>> imm;

    // Combinational op mux for every single-cycle opcode. MUL is not
    // produced here; its result is loaded from the multiplier when done.
    always_comb begin
        w_result     = '0;
        w_takeBranch = 1'b0;
        w_overflow   = 1'b0;
        w_illegal    = 1'b0;
        case (w_opCode)
            OP_MOVE: w_result = in0;
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = (in0[MSB] == in1[MSB]) && (w_sum[MSB] != in0[MSB]);
            end
            OP_AND:  w_result = in0 & in1;
            OP_NOT:  w_result = ~in0;
            OP_NOR:  w_result = ~(in0 | in1);
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_SLL:  w_result = in1 << imm;
            OP_SRL:  w_result = in1 >> imm;
            OP_J, OP_JAL: begin
                w_result     = in1 - pc - 1'b1;
                w_takeBranch = 1'b1;
            end
            OP_LW, OP_SW: w_result = in0 + w_sextImm;
            OP_BEQ: begin
                w_result     = w_sextImm;
                w_takeBranch = (in0 == in1);
            end
            OP_BNE: begin
                w_result     = w_sextImm;
                w_takeBranch = (in0 != in1);
            end
            OP_ADDI: begin
                w_result   = w_addi;
                w_overflow = (in1[MSB] == w_sextImm[MSB]) && (w_addi[MSB] != in1[MSB]);
            end
            OP_LI:   w_result = w_sextImm;
            // Overflow is judged as the addition in0 + (-in1)
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = (in0[MSB] == w_negIn1[MSB]) && (w_diff[MSB] != in0[MSB]);
            end
            OP_MUL:  w_result = '0;
            OP_SRA:  w_result = w_sra;
            OP_XOR:  w_result = in0 ^ in1;
            default: w_illegal = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_mulStart) w_nextState = MUL_BUSY;
            MUL_BUSY: if (w_mulDone)  w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Result register. A MUL accept drops out_valid because in_ready
    // guarantees any previous result is being consumed in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_outValid   <= 1'b0;
            r_takeBranch <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
            r_illegal    <= 1'b0;
        end else if ((r_state == MUL_BUSY) && w_mulDone) begin
            r_out        <= w_mulProduct[WIDTH-1:0];
            r_outValid   <= 1'b1;
            r_takeBranch <= 1'b0;
            r_overflow   <= |w_mulProduct[2*WIDTH-1:WIDTH];
            r_zero       <= (w_mulProduct[WIDTH-1:0] == '0);
            r_illegal    <= 1'b0;
        end else if (w_accept && !w_isMul) begin
            r_out        <= w_result;
            r_outValid   <= 1'b1;
            r_takeBranch <= w_takeBranch;
            r_overflow   <= w_overflow;
            r_zero       <= (w_result == '0);
            r_illegal    <= w_illegal;
        end else if (w_accept) begin
            r_outValid   <= 1'b0;
        end else if (r_outValid && out_ready) begin
            r_outValid   <= 1'b0;
        end
    end

    assign out         = r_out;
    assign out_valid   = r_outValid;
    assign take_branch = r_takeBranch;
    assign overflow    = r_overflow;
    assign zero        = r_zero;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe at WIDTH=8, IMM_W=4.
// Directed scenarios plus randomized requests checked against an
// integer-arithmetic reference model of the instruction set.
module tb_alu_pipe;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int OW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] op = '0;
    logic [IW-1:0] imm = '0;
    logic [W-1:0]  in0 = '0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;
    logic          take_branch;
    logic          overflow;
    logic          zero;
    logic          illegal;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH (W),
        .IMM_W (IW),
        .OP_W  (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .imm         (imm),
        .in0         (in0),
        .in1         (in1),
        .pc          (pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .take_branch (take_branch),
        .overflow    (overflow),
        .zero        (zero),
        .illegal     (illegal)
    );

    // Observed result vector: {out, take_branch, overflow, zero, illegal}
    function automatic logic [11:0] obsVec();
        return {out, take_branch, overflow, zero, illegal};
    endfunction

    function automatic bit outOfRange(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Reference model of the instruction set in plain integer arithmetic
    function automatic logic [11:0] model(input int opc, input int iv, input int a,
                                          input int b, input int p);
        int sa, sb, si, s, r;
        bit tb, ov, ill;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        si = (iv >= 8) ? iv - 16 : iv;
        r = 0; tb = 0; ov = 0; ill = 0;
        case (opc)
            0:  r = a;
            1:  begin s = sa + sb; r = s; ov = outOfRange(s); end
            2:  r = a & b;
            3:  r = ~a;
            4:  r = ~(a | b);
            5:  r = (sa < sb) ? 1 : 0;
            6:  r = (iv >= 8) ? 0 : (b << iv);
            7:  r = (iv >= 8) ? 0 : (b >> iv);
            8, 9: begin r = b - p - 1; tb = 1; end
            10, 11: r = a + si;
            12: begin r = si; tb = (a == b); end
            13: begin r = si; tb = (a != b); end
            14: begin s = sb + si; r = s; ov = outOfRange(s); end
            15: r = si;
            16: begin s = sa + ((b == 128) ? -128 : -sb); r = a - b; ov = outOfRange(s); end
            17: begin s = a * b; r = s; ov = (s > 255); end
            18: r = (iv >= 8) ? ((sb < 0) ? -1 : 0) : (sb >>> iv);
            19: r = a ^ b;
            default: ill = 1;
        endcase
        r = r & 255;
        return {r[7:0], tb, ov, (r == 0), ill};
    endfunction

    // Present a request and hold it until accepted (bounded); returns #1
    // after the accepting edge with in_valid dropped.
    task automatic sendReq(input int opc, input int iv, input int a, input int b,
                           input int p);
        bit ok;
        op = OW'(opc); imm = IW'(iv); in0 = W'(a); in1 = W'(b); pc = W'(p);
        in_valid = 1'b1;
        ok = 0;
        #1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        nTests++;
        if (!ok) begin
            nFail++;
            $display("[TB] FAIL accept_timeout: op=%0d in_ready stayed %b, required 1", opc, in_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        nTests++;
        if ({obsVec(), out_valid, in_ready} !== {12'h000, 1'b0, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL reset_state: got %h/%b/%b required 000/0/1", obsVec(), out_valid, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1;
        sendReq(1, 0, 'h7F, 'h01, 0);
        nTests++;
        if ({out_valid, obsVec()} !== {1'b1, 8'h80, 4'b0100}) begin
            nFail++;
            $display("[TB] FAIL add_ovf: got v=%b %h required v=1 %h", out_valid, obsVec(), {8'h80, 4'b0100});
        end
        sendReq(16, 0, 'h80, 'h01, 0);
        nTests++;
        if ({out_valid, obsVec()} !== {1'b1, 8'h7F, 4'b0100}) begin
            nFail++;
            $display("[TB] FAIL sub_ovf: got v=%b %h required v=1 %h", out_valid, obsVec(), {8'h7F, 4'b0100});
        end
    endtask

    task automatic test_misc_ops();
        sendReq(5, 0, 'hFF, 'h01, 0);
        nTests++;
        if (obsVec() !== {8'h01, 4'b0000}) begin
            nFail++;
            $display("[TB] FAIL slt: got %h required %h", obsVec(), {8'h01, 4'b0000});
        end
        sendReq(14, 'hF, 0, 'h05, 0);
        nTests++;
        if (obsVec() !== {8'h04, 4'b0000}) begin
            nFail++;
            $display("[TB] FAIL addi: got %h required %h", obsVec(), {8'h04, 4'b0000});
        end
        sendReq(12, 'hE, 'h33, 'h33, 0);
        nTests++;
        if (obsVec() !== {8'hFE, 4'b1000}) begin
            nFail++;
            $display("[TB] FAIL beq: got %h required %h", obsVec(), {8'hFE, 4'b1000});
        end
        sendReq(25, 0, 'h12, 'h34, 0);
        nTests++;
        if (obsVec() !== {8'h00, 4'b0011}) begin
            nFail++;
            $display("[TB] FAIL illegal_op: got %h required %h", obsVec(), {8'h00, 4'b0011});
        end
        sendReq(8, 0, 0, 'h20, 'h10);
        nTests++;
        if (obsVec() !== {8'h0F, 4'b1000}) begin
            nFail++;
            $display("[TB] FAIL jump: got %h required %h", obsVec(), {8'h0F, 4'b1000});
        end
    endtask

    task automatic test_mul();
        int cyc, irHigh;
        int a [2] = '{'h10, 'h03};
        int b [2] = '{'h11, 'h05};
        logic [11:0] exp [2] = '{{8'h10, 4'b0100}, {8'h0F, 4'b0000}};
        for (int k = 0; k < 2; k++) begin
            sendReq(17, 0, a[k], b[k], 0);
            cyc = 0; irHigh = 0;
            while (!out_valid && cyc < 30) begin
                if (in_ready) irHigh++;
                @(posedge clk); #1;
                cyc++;
            end
            nTests++;
            if (cyc != 9 || irHigh != 0) begin
                nFail++;
                $display("[TB] FAIL mul_latency: got %0d cycles, in_ready high %0d, required 9 and 0", cyc, irHigh);
            end
            nTests++;
            if (obsVec() !== exp[k]) begin
                nFail++;
                $display("[TB] FAIL mul_result: got %h required %h", obsVec(), exp[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp;
        int bad;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp = model(1, 0, 'h12, 'h34, 0);
        sendReq(1, 0, 'h12, 'h34, 0);
        in0 = 'hFF; in1 = 'hFF; op = 5'd3;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || obsVec() !== exp) bad++;
            @(posedge clk); #1;
        end
        nTests++;
        if (bad != 0) begin
            nFail++;
            $display("[TB] FAIL stall_hold: %0d unstable cycles, last %h v=%b rdy=%b, required %h v=1 rdy=0",
                     bad, obsVec(), out_valid, in_ready, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        nTests++;
        if (out_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL stall_retire: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int opc, iv, a, b, p;
        logic [11:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opc = $urandom_range(0, 19);
            if (opc == 17) opc = 19;
            iv = $urandom_range(0, 15); a = $urandom_range(0, 255);
            b = $urandom_range(0, 255); p = $urandom_range(0, 255);
            exp = model(opc, iv, a, b, p);
            op = OW'(opc); imm = IW'(iv); in0 = W'(a); in1 = W'(b); pc = W'(p);
            in_valid = 1'b1;
            #1;
            nTests++;
            if (in_ready !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL b2b_ready: step %0d in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk); #1;
            nTests++;
            if ({out_valid, obsVec()} !== {1'b1, exp}) begin
                nFail++;
                $display("[TB] FAIL b2b_result: step %0d op=%0d got v=%b %h required v=1 %h",
                         i, opc, out_valid, obsVec(), exp);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        sendReq(0, 0, 'h5A, 0, 0);
        sendReq(17, 0, 'h37, 'h0B, 0);
        repeat (3) @(posedge clk);
        #1;
        nTests++;
        if (in_ready !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL mul_busy_ready: in_ready=%b required 0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        nTests++;
        if ({out_valid, obsVec()} !== 13'h0) begin
            nFail++;
            $display("[TB] FAIL reset_mid_mul: got v=%b %h required v=0 000", out_valid, obsVec());
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        nTests++;
        if (seen != 0 || in_ready !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL mul_abort: out_valid seen %0d, in_ready=%b, required 0 and 1", seen, in_ready);
        end
        sendReq(0, 0, 'hA5, 0, 0);
        nTests++;
        if ({out_valid, obsVec()} !== {1'b1, 8'hA5, 4'b0000}) begin
            nFail++;
            $display("[TB] FAIL move_after_reset: got v=%b %h required v=1 %h", out_valid, obsVec(), {8'hA5, 4'b0000});
        end
    endtask

    task automatic test_random();
        int opc, iv, a, b, p, cyc;
        logic [11:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            opc = $urandom_range(0, 31);
            iv = $urandom_range(0, 15); a = $urandom_range(0, 255);
            b = $urandom_range(0, 255); p = $urandom_range(0, 255);
            exp = model(opc, iv, a, b, p);
            sendReq(opc, iv, a, b, p);
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            nTests++;
            if (cyc != ((opc == 17) ? 9 : 0)) begin
                nFail++;
                $display("[TB] FAIL rand_latency: op=%0d got %0d extra cycles required %0d",
                         opc, cyc, (opc == 17) ? 9 : 0);
            end
            nTests++;
            if ({out_valid, obsVec()} !== {1'b1, exp}) begin
                nFail++;
                $display("[TB] FAIL rand_result: op=%0d imm=%0d a=%h b=%h pc=%h got v=%b %h required v=1 %h",
                         opc, iv, a, b, p, out_valid, obsVec(), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_misc_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
